// File: rtl/harb_cmd_pkg.sv
// harb_cmd_pkg: opcodes, header field positions and decoder state encoding
package harb_cmd_pkg;
  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_REG_WR  = 4'h1;
  localparam logic [3:0] OP_WAVE_WR = 4'h2;
  localparam logic [3:0] OP_ARM     = 4'h3;
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 28;
  localparam int ADDR_MSB = 27;
  localparam int ADDR_LSB = 16;
  localparam int LEN_MSB  = 15;
  localparam int LEN_LSB  = 0;
  typedef enum logic [1:0] {S_HDR, S_REG, S_WAVE, S_DISC} state_e;
endpackage

// File: rtl/spi_cmd_decoder_if.sv
// spi_cmd_decoder_if: FIFO read port, sink write ports and status of the command decoder
interface spi_cmd_decoder_if #(
  parameter int REG_AW  = 8,
  parameter int WAVE_AW = 12
);
  logic [31:0]        fifo_data;
  logic               fifo_valid;
  logic               fifo_rd;
  logic               reg_we;
  logic [REG_AW-1:0]  reg_addr;
  logic [31:0]        reg_data;
  logic               wave_we;
  logic [WAVE_AW-1:0] wave_addr;
  logic [31:0]        wave_data;
  logic               arm_pulse;
  logic [15:0]        pkt_count;
  logic               err_opcode;
  logic               err_timeout;
  logic               clr_err;
  modport master (
    input  fifo_data, fifo_valid, clr_err,
    output fifo_rd, reg_we, reg_addr, reg_data, wave_we, wave_addr, wave_data,
           arm_pulse, pkt_count, err_opcode, err_timeout
  );
  modport slave (
    output fifo_data, fifo_valid, clr_err,
    input  fifo_rd, reg_we, reg_addr, reg_data, wave_we, wave_addr, wave_data,
           arm_pulse, pkt_count, err_opcode, err_timeout
  );
endinterface

// File: rtl/cmd_timeout.sv
// cmd_timeout: loadable idle counter; expired_o fires on the LIMIT-th counted cycle
module cmd_timeout #(
  parameter int LIMIT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         load_i,
  input  logic [$clog2(LIMIT+1)-1:0]   load_val_i,
  input  logic                         en_i,
  output logic                         expired_o
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q;
  assign expired_o = en_i && !clr_i && !load_i && cnt_q >= W'(LIMIT - 1);
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (en_i && !expired_o) cnt_q <= cnt_q + W'(1);
  end
endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: parses FIFO words into register/waveform writes and arm pulses
// with timeout abort, sticky error flags and a completed-packet counter.
module spi_cmd_decoder
  import harb_cmd_pkg::*;
#(
  parameter int REG_AW      = 8,
  parameter int WAVE_AW     = 12,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic              synth_clk,
  input logic              rst,
  spi_cmd_decoder_if.master bus
);
  localparam int AW = ADDR_MSB - ADDR_LSB + 1;
  state_e state_q, state_d;
  logic [15:0] rem_q, rem_d, pkt_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0] opc;
  logic [15:0] len;
  logic pkt_inc, opc_err, arm_set, reg_wr, wave_wr, expired;
  logic reg_we_q, wave_we_q, arm_q, err_op_q, err_to_q;
  logic [REG_AW-1:0] reg_addr_q;
  logic [WAVE_AW-1:0] wave_addr_q;
  logic [31:0] reg_data_q, wave_data_q;
  assign opc = bus.fifo_data[OPC_MSB:OPC_LSB];
  assign len = bus.fifo_data[LEN_MSB:LEN_LSB];
  cmd_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk        (synth_clk),
    .rst        (rst),
    .clr_i      (bus.fifo_valid || state_q == S_HDR),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (state_q != S_HDR),
    .expired_o  (expired)
  );
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    pkt_inc = 1'b0;
    opc_err = 1'b0;
    arm_set = 1'b0;
    reg_wr  = 1'b0;
    wave_wr = 1'b0;
    if (expired) state_d = S_HDR;
    else if (bus.fifo_valid) begin
      case (state_q)
        S_HDR: begin
          case (opc)
            OP_NOP: pkt_inc = 1'b1;
            OP_REG_WR, OP_WAVE_WR: begin
              pkt_inc = len == 16'd0;
              if (len != 16'd0) begin
                state_d = opc == OP_REG_WR ? S_REG : S_WAVE;
                addr_d  = bus.fifo_data[ADDR_MSB:ADDR_LSB];
                rem_d   = len;
              end
            end
            OP_ARM: begin
              arm_set = len == 16'd0;
              pkt_inc = len == 16'd0;
              state_d = len == 16'd0 ? S_HDR : S_DISC;
              rem_d   = len;
            end
            default: begin
              opc_err = 1'b1;
              state_d = len == 16'd0 ? S_HDR : S_DISC;
              rem_d   = len;
            end
          endcase
        end
        S_REG, S_WAVE: begin
          reg_wr  = state_q == S_REG;
          wave_wr = state_q == S_WAVE;
          addr_d  = addr_q + AW'(1);
          rem_d   = rem_q - 16'd1;
          pkt_inc = rem_q == 16'd1;
          state_d = rem_q == 16'd1 ? S_HDR : state_q;
        end
        default: begin
          rem_d   = rem_q - 16'd1;
          state_d = rem_q == 16'd1 ? S_HDR : S_DISC;
        end
      endcase
    end
  end
  always_ff @(posedge synth_clk) begin
    if (rst) begin
      state_q     <= S_HDR;
      rem_q       <= '0;
      addr_q      <= '0;
      pkt_q       <= '0;
      reg_we_q    <= 1'b0;
      wave_we_q   <= 1'b0;
      arm_q       <= 1'b0;
      err_op_q    <= 1'b0;
      err_to_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      wave_addr_q <= '0;
      wave_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      pkt_q     <= pkt_q + 16'(pkt_inc);
      reg_we_q  <= reg_wr;
      wave_we_q <= wave_wr;
      arm_q     <= arm_set;
      err_op_q  <= !bus.clr_err && (err_op_q || opc_err);
      err_to_q  <= !bus.clr_err && (err_to_q || expired);
      if (reg_wr) begin
        reg_addr_q <= addr_q[REG_AW-1:0];
        reg_data_q <= bus.fifo_data;
      end
      if (wave_wr) begin
        wave_addr_q <= addr_q[WAVE_AW-1:0];
        wave_data_q <= bus.fifo_data;
      end
    end
  end
  assign bus.fifo_rd     = !rst;
  assign bus.reg_we      = reg_we_q;
  assign bus.reg_addr    = reg_addr_q;
  assign bus.reg_data    = reg_data_q;
  assign bus.wave_we     = wave_we_q;
  assign bus.wave_addr   = wave_addr_q;
  assign bus.wave_data   = wave_data_q;
  assign bus.arm_pulse   = arm_q;
  assign bus.pkt_count   = pkt_q;
  assign bus.err_opcode  = err_op_q;
  assign bus.err_timeout = err_to_q;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: table-driven cycle vectors plus hand-written timeout and reset sequences
module tb_spi_cmd_decoder;
  localparam int T = 1024;
  typedef struct {
    string        name;
    logic         v;
    logic [31:0]  d;
    logic         c;
    logic [104:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];
  spi_cmd_decoder_if #(.REG_AW(8), .WAVE_AW(12)) bus ();
  spi_cmd_decoder #(.REG_AW(8), .WAVE_AW(12), .TIMEOUT_CYC(T)) dut (
    .synth_clk (clk),
    .rst       (rst),
    .bus       (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [104:0] pk(logic rw, logic [7:0] ra, logic [31:0] rd, logic ww,
                                      logic [11:0] wa, logic [31:0] wd, logic arm,
                                      logic [15:0] pkt, logic eo, logic et);
    return {rw, ra, rd, ww, wa, wd, arm, pkt, eo, et};
  endfunction
  function automatic logic [104:0] act();
    return pk(bus.reg_we, bus.reg_addr, bus.reg_data, bus.wave_we, bus.wave_addr, bus.wave_data,
              bus.arm_pulse, bus.pkt_count, bus.err_opcode, bus.err_timeout);
  endfunction
  task automatic chk(string name, logic [104:0] a, logic [104:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask
  task automatic step(logic v, logic [31:0] d, logic c);
    @(negedge clk);
    bus.fifo_valid = v;
    bus.fifo_data  = d;
    bus.clr_err    = c;
    @(posedge clk);
    #1;
  endtask
  task automatic add(string n, logic v, logic [31:0] d, logic c, logic rw, logic [7:0] ra,
                     logic [31:0] rd, logic ww, logic [11:0] wa, logic [31:0] wd, logic arm,
                     logic [15:0] pkt, logic eo);
    vecs.push_back('{n, v, d, c, pk(rw, ra, rd, ww, wa, wd, arm, pkt, eo, 1'b0)});
  endtask
  initial begin
    bus.fifo_valid = 1'b0;
    bus.fifo_data  = '0;
    bus.clr_err    = 1'b0;
    add("t1_hdr",  1, 32'h1005_0003, 0, 0, 8'h00, 32'h0,        0, 12'h000, 32'h0,  0, 0, 0);
    add("t1_a",    1, 32'h0000_000A, 0, 1, 8'h05, 32'hA,        0, 12'h000, 32'h0,  0, 0, 0);
    add("t1_b",    1, 32'h0000_000B, 0, 1, 8'h06, 32'hB,        0, 12'h000, 32'h0,  0, 0, 0);
    add("t1_c",    1, 32'h0000_000C, 0, 1, 8'h07, 32'hC,        0, 12'h000, 32'h0,  0, 1, 0);
    add("t2_hdr",  1, 32'h2FFE_0003, 0, 0, 8'h07, 32'hC,        0, 12'h000, 32'h0,  0, 1, 0);
    add("t2_d0",   1, 32'h0000_00D0, 0, 0, 8'h07, 32'hC,        1, 12'hFFE, 32'hD0, 0, 1, 0);
    add("t2_d1",   1, 32'h0000_00D1, 0, 0, 8'h07, 32'hC,        1, 12'hFFF, 32'hD1, 0, 1, 0);
    add("t2_d2",   1, 32'h0000_00D2, 0, 0, 8'h07, 32'hC,        1, 12'h000, 32'hD2, 0, 2, 0);
    add("t3_bad",  1, 32'h7000_0002, 0, 0, 8'h07, 32'hC,        0, 12'h000, 32'hD2, 0, 2, 1);
    add("t3_p0",   1, 32'h1111_1111, 0, 0, 8'h07, 32'hC,        0, 12'h000, 32'hD2, 0, 2, 1);
    add("t3_p1",   1, 32'h2222_2222, 0, 0, 8'h07, 32'hC,        0, 12'h000, 32'hD2, 0, 2, 1);
    add("t3_arm",  1, 32'h3000_0000, 0, 0, 8'h07, 32'hC,        0, 12'h000, 32'hD2, 1, 3, 1);
    add("t3_idle", 0, 32'h0,         0, 0, 8'h07, 32'hC,        0, 12'h000, 32'hD2, 0, 3, 1);
    add("t6_clr",  0, 32'h0,         1, 0, 8'h07, 32'hC,        0, 12'h000, 32'hD2, 0, 3, 0);
    add("t6_bad",  1, 32'hF000_0000, 1, 0, 8'h07, 32'hC,        0, 12'h000, 32'hD2, 0, 3, 0);
    add("t6_hdr",  1, 32'h1010_0002, 0, 0, 8'h07, 32'hC,        0, 12'h000, 32'hD2, 0, 3, 0);
    add("t6_g0",   0, 32'h0,         0, 0, 8'h07, 32'hC,        0, 12'h000, 32'hD2, 0, 3, 0);
    add("t6_g1",   0, 32'h0,         0, 0, 8'h07, 32'hC,        0, 12'h000, 32'hD2, 0, 3, 0);
    add("t6_w0",   1, 32'h1234_5678, 0, 1, 8'h10, 32'h12345678, 0, 12'h000, 32'hD2, 0, 3, 0);
    add("t6_g2",   0, 32'h0,         0, 0, 8'h10, 32'h12345678, 0, 12'h000, 32'hD2, 0, 3, 0);
    add("t6_g3",   0, 32'h0,         0, 0, 8'h10, 32'h12345678, 0, 12'h000, 32'hD2, 0, 3, 0);
    add("t6_w1",   1, 32'h9ABC_DEF0, 0, 1, 8'h11, 32'h9ABCDEF0, 0, 12'h000, 32'hD2, 0, 4, 0);
    add("t6_g4",   0, 32'h0,         0, 0, 8'h11, 32'h9ABCDEF0, 0, 12'h000, 32'hD2, 0, 4, 0);
    add("bad_set", 1, 32'hF000_0000, 0, 0, 8'h11, 32'h9ABCDEF0, 0, 12'h000, 32'hD2, 0, 4, 1);
    add("nop",     1, 32'h0000_0000, 0, 0, 8'h11, 32'h9ABCDEF0, 0, 12'h000, 32'hD2, 0, 5, 1);
    add("clr",     0, 32'h0,         1, 0, 8'h11, 32'h9ABCDEF0, 0, 12'h000, 32'hD2, 0, 5, 0);
    add("reg_n0",  1, 32'h1000_0000, 0, 0, 8'h11, 32'h9ABCDEF0, 0, 12'h000, 32'hD2, 0, 6, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", act(), '0);
    chk("reset_fifo_rd", 105'(bus.fifo_rd), 105'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("run_fifo_rd", 105'(bus.fifo_rd), 105'(1));
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].c);
      chk(vecs[i].name, act(), vecs[i].exp);
    end
    // Timeout: two of four writes land, then the idle budget runs out
    step(1, 32'h1000_0004, 0);
    step(1, 32'h0000_00E0, 0);
    chk("t4_w0", act(), pk(1, 8'h00, 32'hE0, 0, 12'h000, 32'hD2, 0, 6, 0, 0));
    step(1, 32'h0000_00E1, 0);
    chk("t4_w1", act(), pk(1, 8'h01, 32'hE1, 0, 12'h000, 32'hD2, 0, 6, 0, 0));
    begin
      int extra = 0;
      for (int k = 0; k < T - 1; k++) begin
        step(0, 32'h0, 0);
        if (bus.reg_we) extra++;
      end
      chk("t4_no_extra_we", 105'(extra), 105'(0));
    end
    chk("t4_before_exp", act(), pk(0, 8'h01, 32'hE1, 0, 12'h000, 32'hD2, 0, 6, 0, 0));
    step(0, 32'h0, 0);
    chk("t4_expired", act(), pk(0, 8'h01, 32'hE1, 0, 12'h000, 32'hD2, 0, 6, 0, 1));
    step(1, 32'h0000_0000, 0);
    chk("t4_nop_after", act(), pk(0, 8'h01, 32'hE1, 0, 12'h000, 32'hD2, 0, 7, 0, 1));
    // Reset mid-packet with a word in flight
    step(1, 32'h2010_0005, 0);
    step(1, 32'h0000_00F0, 0);
    chk("t5_w0", act(), pk(0, 8'h01, 32'hE1, 1, 12'h010, 32'hF0, 0, 7, 0, 1));
    @(negedge clk);
    rst = 1'b1;
    bus.fifo_valid = 1'b1;
    bus.fifo_data  = 32'h0000_00F1;
    @(posedge clk);
    #1;
    chk("t5_rst_out", act(), '0);
    chk("t5_rst_rd", 105'(bus.fifo_rd), 105'(0));
    step(1, 32'h0000_00F2, 0);
    chk("t5_rst_out2", act(), '0);
    @(negedge clk);
    rst = 1'b0;
    bus.fifo_valid = 1'b0;
    step(1, 32'h3000_0000, 0);
    chk("t5_arm", act(), pk(0, 8'h00, 32'h0, 0, 12'h000, 32'h0, 1, 1, 0, 0));
    step(0, 32'h0, 0);
    chk("t5_idle", act(), pk(0, 8'h00, 32'h0, 0, 12'h000, 32'h0, 0, 1, 0, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
